// File: rtl/multiplexer_arbiter.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority arbitration
// and a single registered output stage that refills on the same edge it drains.
module multiplexer_arbiter #(
   parameter int unsigned NBits     = 32,
   parameter int unsigned NChannels = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           Mode,
   input  logic [NChannels*NBits-1:0]     In_Data,
   input  logic [NChannels-1:0]           In_Valid,
   output logic [NChannels-1:0]           In_Ready,
   output logic [NBits-1:0]               Out_Data,
   output logic [$clog2(NChannels)-1:0]   Out_Channel,
   output logic                           Out_Valid,
   input  logic                           Out_Ready
);

   localparam int unsigned SelBits = $clog2(NChannels);

   logic [NBits-1:0]     out_data_q,    out_data_d;
   logic [SelBits-1:0]   out_channel_q, out_channel_d;
   logic                 out_valid_q,   out_valid_d;
   logic [SelBits-1:0]   last_grant_q,  last_grant_d;

   logic [NBits-1:0]     chan_data [NChannels];
   logic [SelBits-1:0]   grant_c;
   logic                 grant_found_c;
   int unsigned          rr_idx_c;
   logic                 load_en_c;
   logic                 any_valid_c;
   logic [NChannels-1:0] ready_c;
   logic                 in_xfer_c;

   for (genvar gi = 0; gi < NChannels; gi++) begin : g_unpack
      assign chan_data[gi] = In_Data[gi*NBits +: NBits];
   end

   assign load_en_c   = !out_valid_q || Out_Ready;
   assign any_valid_c = |In_Valid;

   // Grant selection: lowest index in fixed mode, search after last grant otherwise.
   always_comb begin
      grant_c       = '0;
      grant_found_c = 1'b0;
      rr_idx_c      = 0;
      if (Mode) begin
         for (int unsigned i = 0; i < NChannels; i++) begin
            if (!grant_found_c && In_Valid[SelBits'(i)]) begin
               grant_c       = SelBits'(i);
               grant_found_c = 1'b1;
            end
         end
      end else begin
         for (int unsigned k = 1; k <= NChannels; k++) begin
            rr_idx_c = (32'(last_grant_q) + k) % NChannels;
            if (!grant_found_c && In_Valid[SelBits'(rr_idx_c)]) begin
               grant_c       = SelBits'(rr_idx_c);
               grant_found_c = 1'b1;
            end
         end
      end
   end

   // Ready is one-hot on the winner, suppressed during reset and backpressure.
   always_comb begin
      ready_c = '0;
      if (load_en_c && any_valid_c && !reset) begin
         ready_c[grant_c] = 1'b1;
      end
   end

   assign In_Ready  = ready_c;
   assign in_xfer_c = |(In_Valid & ready_c);

   // Output register and pointer next state; a load overrides a drain.
   always_comb begin
      out_data_d    = out_data_q;
      out_channel_d = out_channel_q;
      out_valid_d   = out_valid_q;
      last_grant_d  = last_grant_q;
      if (in_xfer_c) begin
         out_data_d    = chan_data[grant_c];
         out_channel_d = grant_c;
         out_valid_d   = 1'b1;
         last_grant_d  = grant_c;
      end else if (out_valid_q && Out_Ready) begin
         out_valid_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q    <= '0;
         out_channel_q <= '0;
         out_valid_q   <= 1'b0;
         last_grant_q  <= SelBits'(NChannels - 1);
      end else begin
         out_data_q    <= out_data_d;
         out_channel_q <= out_channel_d;
         out_valid_q   <= out_valid_d;
         last_grant_q  <= last_grant_d;
      end
   end

   assign Out_Data    = out_data_q;
   assign Out_Channel = out_channel_q;
   assign Out_Valid   = out_valid_q;

endmodule

// File: tb/tb_multiplexer_arbiter.sv
// Directed bench for multiplexer_arbiter: expected words are queued as grants are
// predicted and compared against the output register after each edge.
module tb_multiplexer_arbiter;

   localparam int unsigned NBits     = 32;
   localparam int unsigned NChannels = 4;

   logic                       clk;
   logic                       reset;
   logic                       Mode;
   logic [NChannels*NBits-1:0] In_Data;
   logic [NChannels-1:0]       In_Valid;
   logic [NChannels-1:0]       In_Ready;
   logic [NBits-1:0]           Out_Data;
   logic [1:0]                 Out_Channel;
   logic                       Out_Valid;
   logic                       Out_Ready;

   int checks = 0;
   int errors = 0;

   // Each entry: {channel[1:0], data[31:0]} expected in the output register.
   logic [33:0] sb_q[$];

   multiplexer_arbiter #(.NBits(NBits), .NChannels(NChannels)) dut (
      .clk(clk),
      .reset(reset),
      .Mode(Mode),
      .In_Data(In_Data),
      .In_Valid(In_Valid),
      .In_Ready(In_Ready),
      .Out_Data(Out_Data),
      .Out_Channel(Out_Channel),
      .Out_Valid(Out_Valid),
      .Out_Ready(Out_Ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   // One cycle: check predicted ready, update scoreboard, clock, check the output register.
   task automatic step(input string tag, input logic [3:0] exp_rdy);
      logic [1:0]  ch;
      logic [33:0] e;
      #1;
      chk({tag, "/in_ready"}, 32'(In_Ready), 32'(exp_rdy));
      if (reset) begin
         sb_q.delete();
      end else begin
         if (sb_q.size() != 0 && Out_Ready) void'(sb_q.pop_front());
         if (exp_rdy != 4'b0000) begin
            ch = onehot_idx(exp_rdy);
            sb_q.push_back({ch, 32'hA000_0000 | 32'(ch)});
         end
      end
      @(posedge clk);
      #1;
      chk({tag, "/out_valid"}, 32'(Out_Valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
         e = sb_q[0];
         chk({tag, "/out_channel"}, 32'(Out_Channel), 32'(e[33:32]));
         chk({tag, "/out_data"}, Out_Data, e[31:0]);
      end
      if (reset) begin
         chk({tag, "/rst_data"}, Out_Data, 32'h0);
         chk({tag, "/rst_channel"}, 32'(Out_Channel), 32'h0);
      end
   endtask

   initial begin
      for (int i = 0; i < NChannels; i++) In_Data[i*NBits +: NBits] = 32'hA000_0000 | 32'(i);
      reset     = 1'b1;
      Mode      = 1'b0;
      In_Valid  = 4'b1111;
      Out_Ready = 1'b1;

      step("reset0", 4'b0000);
      step("reset1", 4'b0000);
      reset = 1'b0;

      // Round-robin over all channels starting at 0
      step("rr0", 4'b0001);
      step("rr1", 4'b0010);
      step("rr2", 4'b0100);
      step("rr3", 4'b1000);
      step("rr4", 4'b0001);
      step("rr5", 4'b0010);
      step("rr6", 4'b0100);
      step("rr7", 4'b1000);

      // Fixed priority, then channel 0 drops, then back to round-robin after 1
      Mode = 1'b1;
      step("fp0", 4'b0001);
      step("fp1", 4'b0001);
      step("fp2", 4'b0001);
      In_Valid = 4'b1110;
      step("fp_drop0", 4'b0010);
      step("fp_drop1", 4'b0010);
      Mode = 1'b0;
      In_Valid = 4'b1111;
      step("mode_sw", 4'b0100);

      // Backpressure holds the word, release drains and refills on one edge
      Mode = 1'b1;
      step("bp_load", 4'b0001);
      Out_Ready = 1'b0;
      step("bp_hold0", 4'b0000);
      step("bp_hold1", 4'b0000);
      step("bp_hold2", 4'b0000);
      Mode = 1'b0;
      Out_Ready = 1'b1;
      step("bp_release", 4'b0010);

      // Single valid channel wraps to itself, then alternates with channel 1
      In_Valid = 4'b0100;
      step("sparse0", 4'b0100);
      step("sparse1", 4'b0100);
      step("sparse2", 4'b0100);
      In_Valid = 4'b0110;
      step("alt0", 4'b0010);
      step("alt1", 4'b0100);
      step("alt2", 4'b0010);
      step("alt3", 4'b0100);

      // No valid inputs: output drains, pointer holds at 2
      In_Valid = 4'b0000;
      step("idle", 4'b0000);
      In_Valid = 4'b1111;
      step("after_idle", 4'b1000);

      // Reset while a word is stalled in the output register
      Out_Ready = 1'b0;
      step("pre_rst_hold", 4'b0000);
      reset = 1'b1;
      Out_Ready = 1'b1;
      step("mid_reset", 4'b0000);
      reset = 1'b0;
      step("post_rst0", 4'b0001);
      step("post_rst1", 4'b0010);
      Out_Ready = 1'b1;
      In_Valid = 4'b0000;
      step("drain", 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplexer_arbiter.md
# multiplexer_arbiter

Parametrised N-channel multiplexer with valid/ready handshakes, round-robin or fixed-priority arbitration, and one registered output stage. It merges several producer streams onto one consumer, for example several requesters sharing one memory or bus port, with exactly one winner per transfer. It replaces ad-hoc select logic wherever the select must come from live request state instead of a static control bit.

## Interface
- NBits, 32, data width per channel
- NChannels, 4, number of input channels (must be at least 2)
- SelBits is a derived localparam, not a parameter: $clog2(NChannels)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- In_Data  input  NChannels*NBits  flattened channel data; channel i occupies bits [i*NBits +: NBits]
- In_Valid  input  NChannels  per-channel valid
- In_Ready  output  NChannels  per-channel ready, combinational, at most one bit high (one-hot or zero)
- Out_Data  output  NBits  registered data of the granted word
- Out_Channel  output  SelBits  registered index of the channel that supplied Out_Data
- Out_Valid  output  1  output register holds a word
- Out_Ready  input  1  consumer accepts the word

One clock domain. Reset is synchronous and active-high.

## Operation
- Load enable: load_en = !Out_Valid || Out_Ready.
- Grant g is computed combinationally from In_Valid, Mode and pointer Last_Grant.
  - Mode=0: first valid channel found searching Last_Grant+1, Last_Grant+2, … wrapping modulo NChannels, ending at Last_Grant itself.
  - Mode=1: lowest-index valid channel.
- In_Ready[g] = load_en && |In_Valid && !reset. All other In_Ready bits are 0.
- An input transfer occurs on channel g when In_Valid[g] && In_Ready[g] at a clock edge.
- On an input transfer:
  - Out_Data <= channel g data
  - Out_Channel <= g
  - Out_Valid <= 1
  - Last_Grant <= g. The pointer updates in both modes, so a switch back to Mode=0 resumes fairly.
- On an output transfer (Out_Valid && Out_Ready) with no input transfer: Out_Valid <= 0. Out_Data and Out_Channel hold their values.
- Simultaneous output and input transfer in the same cycle: the new word replaces the old one. No bubble is inserted.
- While Out_Valid && !Out_Ready:
  - Out_Data and Out_Channel remain stable.
  - All In_Ready bits are 0.
  - Last_Grant is frozen.
- No valid inputs: In_Ready = 0 and Last_Grant is unchanged.
- Mode may change on any cycle. It takes effect on that cycle's grant computation.
- Reset values:
  - Out_Valid = 0, Out_Data = 0, Out_Channel = 0
  - Last_Grant = NChannels-1, so the first round-robin search starts at channel 0
  - In_Ready = 0 during every reset cycle
- Reset mid-operation: any word held in the output register is discarded. No input transfer is accepted in a reset cycle.

## Timing
- Latency: 1 cycle from input transfer edge to Out_Valid=1 with the matching data.
- Throughput: one word per cycle while Out_Ready=1 and at least one input is valid.
- In_Ready has a combinational path from In_Valid, Mode, Out_Valid and Out_Ready. There is no combinational path from any input to Out_Data, Out_Channel or Out_Valid.
- Round-robin fairness: with all channels valid continuously, each channel is granted exactly once in every NChannels consecutive input transfers.
- Producers must hold In_Valid and data until their handshake completes. The block never drops or duplicates an accepted word.

## Test plan
Defaults for all scenarios: NBits=32, NChannels=4, channel i data = 0xA000_000i.
- Reset held 2 cycles with In_Valid=4'b1111, Out_Ready=1, Mode=0 -> In_Ready=0000, Out_Valid=0, Out_Data=0 throughout reset. The first cycle after reset gives In_Ready=0001, and Out_Data=0xA000_0000 with Out_Channel=0 one cycle later.
- Mode=0, all channels valid, Out_Ready=1 for 8 cycles -> Out_Channel sequence 0,1,2,3,0,1,2,3 with one word per cycle and data matching the channel.
- Mode=1, all channels valid -> Out_Channel=0 every cycle. Drop In_Valid[0] -> Out_Channel=1 from the next word onward. Switch to Mode=0 with Last_Grant=1 -> next grant is channel 2.
- Backpressure: Out_Ready=0 after the first word is loaded, held 3 cycles -> Out_Valid=1, Out_Data=0xA000_0000 stable, In_Ready=0000. Raise Out_Ready -> the old word is consumed and channel 1 is loaded on the same edge.
- Sparse wrap-around: only In_Valid[2]=1, Mode=0, Last_Grant=2 -> channel 2 is granted on every cycle. Add In_Valid[1]=1 -> grants alternate 1,2,1,2.
- Reset asserted while Out_Valid=1 and Out_Ready=0 -> the next cycle shows Out_Valid=0 and In_Ready=0000. After reset release, the first grant is channel 0 (Last_Grant=3).
